// File: rtl/mux_drv_pkg.sv
// Shared types and iw/ow field layout for the mux project driver.
package mux_drv_pkg;

  localparam int IW_W    = 18;
  localparam int OW_W    = 24;
  localparam int FIELD_W = 8;

  // iw: project clock, project reset, then the two input bytes
  localparam int IW_CLK_BIT  = 0;
  localparam int IW_RSTN_BIT = 1;
  localparam int IW_UI_LSB   = 2;
  localparam int IW_UIO_LSB  = 10;

  // ow: outputs, bidir outputs, bidir output enables
  localparam int OW_UO_LSB  = 0;
  localparam int OW_UIO_LSB = 8;
  localparam int OW_OE_LSB  = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CLK_HI,
    CLK_LO,
    SAMPLE,
    RESP
  } drv_state_e;

endpackage

// File: rtl/mux_drv_phase_timer.sv
// Loadable 8-bit down-counter timing the settle and clock-phase intervals.
// done is high in the last cycle of a loaded interval (and while idle).
module mux_drv_phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic       done
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (count != 8'd0)
      count <= count - 8'd1;
  end

  assign done = (count <= 8'd1);

endmodule

// File: rtl/mux_proj_driver.sv
// Drives a muxed project: applies inputs, issues N project-clock pulses, captures ow.
// Optional macro MUX_DRV_COMPARE_EN enables the ow-vs-expected mismatch flag.
module mux_proj_driver
  import mux_drv_pkg::*;
#(
  parameter int HALF_PERIOD = 2,
  parameter int SETTLE      = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_ena,
  input  logic [7:0]      cmd_ui_in,
  input  logic [7:0]      cmd_uio_in,
  input  logic            cmd_rst_n,
  input  logic [7:0]      cmd_pulses,
  input  logic [OW_W-1:0] cmd_expect,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [OW_W-1:0] rsp_ow,
  output logic            rsp_mismatch,
  output logic            ena,
  output logic [IW_W-1:0] iw,
  input  logic [OW_W-1:0] ow
);

  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);
  localparam logic [7:0] HALF_CNT   = 8'(HALF_PERIOD);

  drv_state_e      state, next_state;
  logic [7:0]      pulses_left;
  logic            timer_load, timer_done;
  logic [7:0]      timer_value;
  logic            proj_clk;
  logic [IW_W-1:0] iw_fields, cmd_iw;
  logic            accept;

  assign accept    = cmd_valid && cmd_ready;
  assign cmd_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);

  mux_drv_phase_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  // The timer is reloaded on every entry into a timed state.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_valid) next_state = SETUP;
      SETUP:   if (timer_done) next_state = (pulses_left != 8'd0) ? CLK_HI : SAMPLE;
      CLK_HI:  if (timer_done) next_state = CLK_LO;
      CLK_LO:  if (timer_done) next_state = (pulses_left != 8'd1) ? CLK_HI : SAMPLE;
      SAMPLE:  next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (rst) next_state = IDLE;
    timer_load  = (next_state != state) &&
                  ((next_state == SETUP) || (next_state == CLK_HI) || (next_state == CLK_LO));
    timer_value = (next_state == SETUP) ? SETTLE_CNT : HALF_CNT;
  end

  always_comb begin
    cmd_iw                            = '0;
    cmd_iw[IW_RSTN_BIT]               = cmd_rst_n;
    cmd_iw[IW_UI_LSB +: FIELD_W]      = cmd_ui_in;
    cmd_iw[IW_UIO_LSB +: FIELD_W]     = cmd_uio_in;
  end

  // Project clock is registered from next_state so it is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulses_left <= '0;
      proj_clk    <= 1'b0;
      iw_fields   <= '0;
      ena         <= 1'b0;
      rsp_ow      <= '0;
    end else begin
      proj_clk <= (next_state == CLK_HI);
      if (accept) begin
        iw_fields   <= cmd_iw;
        ena         <= cmd_ena;
        pulses_left <= cmd_pulses;
      end
      if (state == CLK_LO && timer_done)
        pulses_left <= pulses_left - 8'd1;
      if (state == SAMPLE)
        rsp_ow <= ow;
    end
  end

  assign iw = iw_fields | {{(IW_W-1){1'b0}}, proj_clk};

`ifdef MUX_DRV_COMPARE_EN
  logic [OW_W-1:0] expect_q;
  logic            mismatch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      expect_q   <= '0;
      mismatch_q <= 1'b0;
    end else begin
      if (accept)
        expect_q <= cmd_expect;
      if (state == SAMPLE)
        mismatch_q <= (ow != expect_q);
    end
  end

  assign rsp_mismatch = mismatch_q;
`else
  logic unused_expect;
  assign unused_expect = ^cmd_expect;
  assign rsp_mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_mux_proj_driver.sv
// Bench for mux_proj_driver: cycle-age reference model checked every cycle,
// plus directed scenarios with literal latency/pulse/field expectations.
module tb_mux_proj_driver;

  localparam int HP = 2;
  localparam int ST = 1;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ena = 1'b0, cmd_rst_n = 1'b0, rsp_ready = 1'b0;
  logic [7:0]  cmd_ui_in = '0, cmd_uio_in = '0, cmd_pulses = '0;
  logic [23:0] cmd_expect = '0, ow = '0;
  logic        cmd_ready, rsp_valid, rsp_mismatch, ena;
  logic [23:0] rsp_ow;
  logic [17:0] iw;

  int n_checks = 0, n_fail = 0, cyc = 0;

  // ow driver state
  bit          ow_hold = 1'b0;
  logic [23:0] ow_fixed = '0;

  // reference model state
  bit          m_busy = 1'b0;
  int          m_age = 0, m_n = 0;
  logic        m_ena = 1'b0, m_mis = 1'b0;
  logic [17:0] m_iw = '0;
  logic [23:0] m_expect = '0, m_rsp_ow = '0;

  // monitor of the most recent command
  int          mon_acc_cyc = -10, mon_acc_cnt = 0, mon_lat = -1;
  int          mon_pulses = 0, mon_badwin = 0, mon_hi_len = 0;
  logic        mon_prev_clk = 1'b0, mon_mis_v = 1'b0;
  logic [17:0] mon_iw1 = '0;

  mux_proj_driver #(.HALF_PERIOD(HP), .SETTLE(ST)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_ena      (cmd_ena),
    .cmd_ui_in    (cmd_ui_in),
    .cmd_uio_in   (cmd_uio_in),
    .cmd_rst_n    (cmd_rst_n),
    .cmd_pulses   (cmd_pulses),
    .cmd_expect   (cmd_expect),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_ow       (rsp_ow),
    .rsp_mismatch (rsp_mismatch),
    .ena          (ena),
    .iw           (iw),
    .ow           (ow)
  );

  always #5 clk = ~clk;

  function automatic int lat_of(input int n);
    return 2 + ST + 2 * HP * n;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ow = ow_hold ? ow_fixed : 24'($urandom);
    end
  end

  // Per-cycle compare against the model, then advance the model on this cycle's inputs.
  initial begin : compare
    bit   exp_clk, exp_valid;
    forever begin
      @(negedge clk);
      cyc++;
      exp_clk   = m_busy && (m_age >= 1 + ST) && (m_age < 1 + ST + 2 * HP * m_n) &&
                  (((m_age - 1 - ST) % (2 * HP)) < HP);
      exp_valid = m_busy && (m_age >= lat_of(m_n));
      check_output("cmd_ready", 32'(cmd_ready), 32'(!m_busy && !rst));
      check_output("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      check_output("ena", 32'(ena), 32'(m_ena));
      check_output("iw", 32'(iw), 32'(m_iw | {17'b0, exp_clk}));
      check_output("rsp_ow", 32'(rsp_ow), 32'(m_rsp_ow));
      check_output("rsp_mismatch", 32'(rsp_mismatch), 32'(m_mis));

      if (mon_lat < 0 && rsp_valid) begin
        mon_lat   = cyc - mon_acc_cyc;
        mon_mis_v = rsp_mismatch;
      end
      if (cyc == mon_acc_cyc + 1) mon_iw1 = iw;
      if (iw[0]) begin
        if (!mon_prev_clk) mon_pulses++;
        mon_hi_len++;
      end else if (mon_prev_clk) begin
        if (mon_hi_len != HP) mon_badwin++;
        mon_hi_len = 0;
      end
      mon_prev_clk = iw[0];
      if (!rst && cmd_valid && cmd_ready) begin
        mon_acc_cyc = cyc;
        mon_acc_cnt++;
        mon_lat     = -1;
        mon_pulses  = 0;
        mon_badwin  = 0;
        mon_hi_len  = 0;
      end

      if (rst) begin
        m_busy = 1'b0; m_ena = 1'b0; m_iw = '0; m_rsp_ow = '0; m_mis = 1'b0;
      end else if (!m_busy) begin
        if (cmd_valid) begin
          m_busy   = 1'b1;
          m_age    = 1;
          m_n      = int'(cmd_pulses);
          m_ena    = cmd_ena;
          m_iw     = {cmd_uio_in, cmd_ui_in, cmd_rst_n, 1'b0};
          m_expect = cmd_expect;
        end
      end else begin
        if (m_age == 1 + ST + 2 * HP * m_n) begin
          m_rsp_ow = ow;
`ifdef MUX_DRV_COMPARE_EN
          m_mis = (ow != m_expect);
`else
          m_mis = 1'b0;
`endif
        end
        if (m_age >= lat_of(m_n) && rsp_ready) m_busy = 1'b0;
        m_age++;
      end
    end
  end

  task automatic start_cmd(input logic e, input logic [7:0] ui, input logic [7:0] uio,
                           input logic rn, input logic [7:0] p, input logic [23:0] ex);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    cmd_ena = e; cmd_ui_in = ui; cmd_uio_in = uio; cmd_rst_n = rn;
    cmd_pulses = p; cmd_expect = ex; cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    check_output("accept_in_time", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_ena    = 1'($urandom);
    cmd_ui_in  = 8'($urandom);
    cmd_uio_in = 8'($urandom);
    cmd_rst_n  = 1'($urandom);
    cmd_pulses = 8'($urandom);
    cmd_expect = 24'($urandom);
  endtask

  task automatic finish_cmd(input bit rand_ready, input int hold);
    bit          done = 1'b0;
    int          vcnt = 0;
    logic [23:0] snap = '0;
    rsp_ready = (hold > 0) ? 1'b0 : (rand_ready ? 1'($urandom) : 1'b1);
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (vcnt == 0) snap = rsp_ow;
        if (rsp_ready) done = 1'b1;
        vcnt++;
        if (hold > 0 && vcnt == hold) check_output("hold_rsp_ow", 32'(rsp_ow), 32'(snap));
      end
      @(posedge clk);
      #1;
      if (done) begin
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
      end else begin
        rsp_ready = (vcnt < hold) ? 1'b0 : (rand_ready ? 1'($urandom) : 1'b1);
        cmd_valid = (hold > 0 && vcnt == 3);
      end
    end
    check_output("rsp_in_time", 32'(done), 32'd1);
  endtask

  task automatic apply_stimulus(input logic e, input logic [7:0] ui, input logic [7:0] uio,
                                input logic rn, input logic [7:0] p, input logic [23:0] ex,
                                input bit rand_ready, input int hold);
    start_cmd(e, ui, uio, rn, p, ex);
    finish_cmd(rand_ready, hold);
  endtask

  initial begin
    #(60000 * 10);
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int cnt_before;
    bit found;
    logic [23:0] v;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("reset_iw", 32'(iw), 32'd0);
    check_output("reset_ena", 32'(ena), 32'd0);
    check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("reset_rsp_ow", 32'(rsp_ow), 32'd0);
    check_output("reset_cmd_ready", 32'(cmd_ready), 32'd1);

    apply_stimulus(1'b1, 8'hA5, 8'h3C, 1'b1, 8'd0, 24'd0, 1'b0, 0);
    check_output("p0_iw_cycle1", 32'(mon_iw1), 32'h0F296);
    check_output("p0_latency", 32'(mon_lat), 32'd3);
    check_output("p0_pulses", 32'(mon_pulses), 32'd0);

    apply_stimulus(1'b0, 8'h11, 8'h22, 1'b1, 8'd1, 24'd0, 1'b0, 0);
    check_output("p1_latency", 32'(mon_lat), 32'd7);

    apply_stimulus(1'b1, 8'h5A, 8'hC3, 1'b0, 8'd3, 24'd0, 1'b0, 0);
    check_output("p3_pulses", 32'(mon_pulses), 32'd3);
    check_output("p3_bad_windows", 32'(mon_badwin), 32'd0);
    check_output("p3_latency", 32'(mon_lat), 32'd15);

    cnt_before = mon_acc_cnt;
    apply_stimulus(1'b1, 8'h01, 8'h02, 1'b1, 8'd1, 24'd0, 1'b0, 10);
    check_output("hold_single_accept", 32'(mon_acc_cnt - cnt_before), 32'd1);

    ow_hold = 1'b1; ow_fixed = 24'h123456;
    apply_stimulus(1'b1, 8'h00, 8'h00, 1'b1, 8'd2, 24'h123456, 1'b0, 0);
    check_output("cmp_equal", 32'(mon_mis_v), 32'd0);
    apply_stimulus(1'b1, 8'h00, 8'h00, 1'b1, 8'd2, 24'h123457, 1'b0, 0);
`ifdef MUX_DRV_COMPARE_EN
    check_output("cmp_differ", 32'(mon_mis_v), 32'd1);
`else
    check_output("cmp_differ", 32'(mon_mis_v), 32'd0);
`endif
    ow_hold = 1'b0;

    start_cmd(1'b1, 8'hFF, 8'hEE, 1'b1, 8'd5, 24'd0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (iw[0]) begin found = 1'b1; break; end
    end
    check_output("abort_saw_clk_hi", 32'(found), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cmd_ena = 1'b1; cmd_ui_in = 8'h42; cmd_uio_in = 8'h24; cmd_rst_n = 1'b1;
    cmd_pulses = 8'd1; cmd_valid = 1'b1;
    cnt_before = mon_acc_cnt;
    @(negedge clk);
    check_output("abort_iw", 32'(iw), 32'd0);
    check_output("abort_ena", 32'(ena), 32'd0);
    check_output("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check_output("accept_after_reset", 32'(mon_acc_cnt - cnt_before), 32'd1);
    finish_cmd(1'b0, 0);
    check_output("post_reset_latency", 32'(mon_lat), 32'd7);

    apply_stimulus(1'b1, 8'h80, 8'h01, 1'b1, 8'd255, 24'd0, 1'b1, 0);
    check_output("p255_pulses", 32'(mon_pulses), 32'd255);
    check_output("p255_bad_windows", 32'(mon_badwin), 32'd0);
    check_output("p255_latency", 32'(mon_lat), 32'd1023);

    for (int k = 0; k < 25; k++) begin
      v = 24'($urandom);
      ow_hold  = 1'($urandom);
      ow_fixed = v;
      apply_stimulus(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                     8'($urandom_range(0, 6)), ($urandom_range(0, 1) == 0) ? v : 24'($urandom),
                     1'b1, 0);
      check_output("rand_latency", 32'(mon_lat), 32'(lat_of(int'(dut.cmd_pulses) * 0 + mon_pulses)));
    end
    ow_hold = 1'b0;

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
